// File: rtl/step_move_gen_pkg.sv
// Shared types and constants for the step-piece move generator.
package step_move_gen_pkg;

   // Step pieces the generator knows how to enumerate.
   typedef enum logic {
      KING   = 1'b0,
      KNIGHT = 1'b1
   } piece_step_e;

   // Enumeration control states.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   localparam int OFF_W    = 3;   // signed offset width, covers -2..+2
   localparam int NUM_OFFS = 8;   // candidates per origin square

   // Signed 3-bit single-axis offsets.
   localparam logic signed [OFF_W-1:0] OFF_P2 = 3'sb010;
   localparam logic signed [OFF_W-1:0] OFF_P1 = 3'sb001;
   localparam logic signed [OFF_W-1:0] OFF_Z  = 3'sb000;
   localparam logic signed [OFF_W-1:0] OFF_M1 = 3'sb111;
   localparam logic signed [OFF_W-1:0] OFF_M2 = 3'sb110;

   // Row of a packed {row, col} square for a board of 2^w per side.
   function automatic int unsigned row(input int unsigned sq, input int unsigned w);
      return (sq >> w) & ((32'd1 << w) - 32'd1);
   endfunction

   // Column of a packed {row, col} square for a board of 2^w per side.
   function automatic int unsigned col(input int unsigned sq, input int unsigned w);
      return sq & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/step_move_gen_lut.sv
// Offset table: (piece, index) -> signed (drow, dcol) for king and knight.
module step_offset_lut
   import step_move_gen_pkg::*;
(
   input  piece_step_e             piece_i,
   input  logic [2:0]              idx_i,
   output logic signed [OFF_W-1:0] drow_o,
   output logic signed [OFF_W-1:0] dcol_o
);

   // King walks the ring starting north, knight starts at (+2,+1); both clockwise.
   always_comb begin
      drow_o = OFF_Z;
      dcol_o = OFF_Z;
      if (piece_i == KING) begin
         unique case (idx_i)
            3'd0: begin drow_o = OFF_P1; dcol_o = OFF_Z;  end
            3'd1: begin drow_o = OFF_P1; dcol_o = OFF_P1; end
            3'd2: begin drow_o = OFF_Z;  dcol_o = OFF_P1; end
            3'd3: begin drow_o = OFF_M1; dcol_o = OFF_P1; end
            3'd4: begin drow_o = OFF_M1; dcol_o = OFF_Z;  end
            3'd5: begin drow_o = OFF_M1; dcol_o = OFF_M1; end
            3'd6: begin drow_o = OFF_Z;  dcol_o = OFF_M1; end
            3'd7: begin drow_o = OFF_P1; dcol_o = OFF_M1; end
         endcase
      end else begin
         unique case (idx_i)
            3'd0: begin drow_o = OFF_P2; dcol_o = OFF_P1; end
            3'd1: begin drow_o = OFF_P1; dcol_o = OFF_P2; end
            3'd2: begin drow_o = OFF_M1; dcol_o = OFF_P2; end
            3'd3: begin drow_o = OFF_M2; dcol_o = OFF_P1; end
            3'd4: begin drow_o = OFF_M2; dcol_o = OFF_M1; end
            3'd5: begin drow_o = OFF_M1; dcol_o = OFF_M2; end
            3'd6: begin drow_o = OFF_P1; dcol_o = OFF_M2; end
            3'd7: begin drow_o = OFF_P2; dcol_o = OFF_M1; end
         endcase
      end
   end

endmodule

// File: rtl/step_move_gen.sv
// Step-piece move generator: latches an origin on start, then hands out the
// eight king/knight destinations one per valid/ready handshake. Off-board
// candidates are either dropped internally or presented with in_bounds low.
module step_move_gen
   import step_move_gen_pkg::*;
#(
   parameter int COORD_W       = 3,     // board side is 2^COORD_W, needs >= 2
   parameter bit SKIP_OFFBOARD = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 piece_i,
   input  logic [2*COORD_W-1:0] pos_i,
   output logic                 busy_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [2:0]           number_o,
   output logic [COORD_W-1:0]   row_o,
   output logic [COORD_W-1:0]   col_o,
   output logic [2*COORD_W-1:0] out_pos_o,
   output logic [2*COORD_W-1:0] origin_o,
   output logic                 in_bounds_o,
   output logic                 done_o
);

   // Two guard bits: one for the sign, one for overflow past the far edge.
   localparam int SW = COORD_W + 2;

   state_e                 state_q;
   piece_step_e            piece_q;
   logic [2:0]             idx_q, idx_d;
   logic [2*COORD_W-1:0]   origin_q;
   logic                   done_q, done_d;

   logic signed [OFF_W-1:0] drow, dcol;
   logic [COORD_W-1:0]      orow, ocol;
   logic signed [SW-1:0]    rsum, csum;
   logic                    run, inb, vld, retire, last;

   step_offset_lut u_lut (
      .piece_i (piece_q),
      .idx_i   (idx_q),
      .drow_o  (drow),
      .dcol_o  (dcol)
   );

   assign orow = origin_q[2*COORD_W-1:COORD_W];
   assign ocol = origin_q[COORD_W-1:0];

   // Candidate coordinates: zero-extended origin plus sign-extended offset.
   always_comb begin
      rsum = $signed({2'b00, orow}) + SW'(drow);
      csum = $signed({2'b00, ocol}) + SW'(dcol);
   end

   // On board exactly when neither guard bit is set (not negative, not >= side).
   always_comb begin
      inb    = (rsum[SW-1 -: 2] == 2'b00) && (csum[SW-1 -: 2] == 2'b00);
      run    = (state_q == S_RUN);
      vld    = run && (inb || !SKIP_OFFBOARD);
      // A suppressed candidate retires on its own in a single silent cycle.
      retire = run && ((vld && out_ready_i) || (SKIP_OFFBOARD && !inb));
      last   = retire && (idx_q == 3'd7);
      idx_d  = retire ? idx_q + 3'd1 : idx_q;
      done_d = last;
   end

   // Control FSM: origin/piece capture, index stepping and the done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         piece_q  <= KING;
         idx_q    <= '0;
         origin_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= done_d;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q  <= S_RUN;
                  origin_q <= pos_i;
                  piece_q  <= piece_step_e'(piece_i);
                  idx_q    <= '0;
               end
            end
            S_RUN: begin
               idx_q <= idx_d;   // wraps to 0 as index 7 retires
               if (last) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o      = run;
   assign out_valid_o = vld;
   assign number_o    = idx_q;
   assign row_o       = rsum[COORD_W-1:0];
   assign col_o       = csum[COORD_W-1:0];
   assign out_pos_o   = {row_o, col_o};
   assign origin_o    = origin_q;
   assign in_bounds_o = inb;
   assign done_o      = done_q;

endmodule

// File: tb/tb_step_move_gen.sv
// Bench for step_move_gen: three instances (3-bit skip, 3-bit flag, 4-bit skip)
// share stimulus and are checked cycle by cycle against a candidate-list model.
module tb_step_move_gen;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, piece = 1'b0, out_ready = 1'b0;
   logic [5:0] pos3 = '0;
   logic [7:0] pos4 = '0;

   logic       busy_w[3], vld_w[3], inb_w[3], done_w[3];
   logic [2:0] num_w[3];
   logic [5:0] op0, op1, org0, org1;
   logic [2:0] r0, c0, r1, c1;
   logic [7:0] op2, org2;
   logic [3:0] r2, c2;

   int o_pos[3], o_row[3], o_col[3], o_org[3];

   always #5 clk = ~clk;

   step_move_gen #(.COORD_W(3), .SKIP_OFFBOARD(1'b1)) dut_s3 (
      .clk(clk), .rst(rst), .start_i(start), .piece_i(piece), .pos_i(pos3),
      .busy_o(busy_w[0]), .out_valid_o(vld_w[0]), .out_ready_i(out_ready),
      .number_o(num_w[0]), .row_o(r0), .col_o(c0), .out_pos_o(op0),
      .origin_o(org0), .in_bounds_o(inb_w[0]), .done_o(done_w[0]));

   step_move_gen #(.COORD_W(3), .SKIP_OFFBOARD(1'b0)) dut_f3 (
      .clk(clk), .rst(rst), .start_i(start), .piece_i(piece), .pos_i(pos3),
      .busy_o(busy_w[1]), .out_valid_o(vld_w[1]), .out_ready_i(out_ready),
      .number_o(num_w[1]), .row_o(r1), .col_o(c1), .out_pos_o(op1),
      .origin_o(org1), .in_bounds_o(inb_w[1]), .done_o(done_w[1]));

   step_move_gen #(.COORD_W(4), .SKIP_OFFBOARD(1'b1)) dut_s4 (
      .clk(clk), .rst(rst), .start_i(start), .piece_i(piece), .pos_i(pos4),
      .busy_o(busy_w[2]), .out_valid_o(vld_w[2]), .out_ready_i(out_ready),
      .number_o(num_w[2]), .row_o(r2), .col_o(c2), .out_pos_o(op2),
      .origin_o(org2), .in_bounds_o(inb_w[2]), .done_o(done_w[2]));

   always_comb begin
      o_pos[0] = int'(op0);  o_pos[1] = int'(op1);  o_pos[2] = int'(op2);
      o_row[0] = int'(r0);   o_row[1] = int'(r1);   o_row[2] = int'(r2);
      o_col[0] = int'(c0);   o_col[1] = int'(c1);   o_col[2] = int'(c2);
      o_org[0] = int'(org0); o_org[1] = int'(org1); o_org[2] = int'(org2);
   end

   // Reference tables straight from the piece movement rules.
   int K_DR[8] = '{ 1,  1,  0, -1, -1, -1,  0,  1};
   int K_DC[8] = '{ 0,  1,  1,  1,  0, -1, -1, -1};
   int N_DR[8] = '{ 2,  1, -1, -2, -2, -1,  1,  2};
   int N_DC[8] = '{ 1,  2,  2,  1, -1, -2, -2, -1};

   int cw[3]  = '{3, 3, 4};
   bit skp[3] = '{1'b1, 1'b0, 1'b1};

   int c_pos[3][8], c_row[3][8], c_col[3][8];
   bit c_inb[3][8];
   int m_k[3], m_org[3];
   bit m_run[3], m_done[3];

   int pres_pos[3][$];
   int pres_num[3][$];
   int pres_inb[3][$];

   int n_run = 0, n_fail = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_run++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cmp_q(input string tag, input int got[$], input int exp[$]);
      chk({tag, "_len"}, got.size(), exp.size());
      for (int k = 0; k < got.size() && k < exp.size(); k++)
         chk($sformatf("%s[%0d]", tag, k), got[k], exp[k]);
   endtask

   // Build the full candidate list of one instance for a given origin.
   task automatic build(input int i, input bit pc, input int r, input int c);
      int side;
      side = 1 << cw[i];
      m_org[i] = r * side + c;
      for (int k = 0; k < 8; k++) begin
         int nr, nc;
         nr = r + (pc ? N_DR[k] : K_DR[k]);
         nc = c + (pc ? N_DC[k] : K_DC[k]);
         c_inb[i][k] = (nr >= 0) && (nr < side) && (nc >= 0) && (nc < side);
         nr = (nr + side) % side;
         nc = (nc + side) % side;
         c_row[i][k] = nr;
         c_col[i][k] = nc;
         c_pos[i][k] = nr * side + nc;
      end
   endtask

   // One cycle: drive inputs, check all instances, advance the model, wait.
   task automatic tick(input bit rdy, input bit st);
      out_ready = rdy;
      start     = st;
      for (int i = 0; i < 3; i++) begin
         bit ev;
         int k;
         k  = m_k[i];
         ev = 1'b0;
         if (m_run[i]) ev = c_inb[i][k] || !skp[i];
         chk($sformatf("busy[%0d]", i), int'(busy_w[i]), int'(m_run[i]));
         chk($sformatf("valid[%0d]", i), int'(vld_w[i]), int'(ev));
         chk($sformatf("done[%0d]", i), int'(done_w[i]), int'(m_done[i]));
         if (m_run[i]) begin
            chk($sformatf("number[%0d]", i), int'(num_w[i]), k);
            chk($sformatf("origin[%0d]", i), o_org[i], m_org[i]);
         end
         if (ev) begin
            chk($sformatf("pos[%0d]", i), o_pos[i], c_pos[i][k]);
            chk($sformatf("row[%0d]", i), o_row[i], c_row[i][k]);
            chk($sformatf("col[%0d]", i), o_col[i], c_col[i][k]);
            chk($sformatf("inb[%0d]", i), int'(inb_w[i]), int'(c_inb[i][k]));
            if (rdy) begin
               pres_pos[i].push_back(o_pos[i]);
               pres_num[i].push_back(int'(num_w[i]));
               pres_inb[i].push_back(int'(inb_w[i]));
            end
         end
         m_done[i] = 1'b0;
         if (m_run[i]) begin
            if ((ev && rdy) || (skp[i] && !c_inb[i][k])) begin
               if (k == 7) begin
                  m_run[i]  = 1'b0;
                  m_done[i] = 1'b1;
                  m_k[i]    = 0;
               end else begin
                  m_k[i] = k + 1;
               end
            end
         end else if (st) begin
            if (i == 2) build(i, piece, int'(pos4[7:4]), int'(pos4[3:0]));
            else        build(i, piece, int'(pos3[5:3]), int'(pos3[2:0]));
            m_run[i] = 1'b1;
            m_k[i]   = 0;
         end
      end
      @(negedge clk);
   endtask

   // Start an enumeration on all instances and follow it to completion.
   task automatic run_enum(input bit pc, input int r3, input int c3, input int r4,
                           input int c4, input int rdy_pct, input int mid_start,
                           input bit tail);
      int n;
      bit any;
      for (int i = 0; i < 3; i++) begin
         pres_pos[i].delete();
         pres_num[i].delete();
         pres_inb[i].delete();
      end
      piece = pc;
      pos3  = 6'(r3 * 8 + c3);
      pos4  = 8'(r4 * 16 + c4);
      tick(int'($urandom_range(99)) < rdy_pct, 1'b1);
      n   = 0;
      any = 1'b1;
      while (any && n < 300) begin
         bit st;
         st = (n == mid_start);
         if (st) begin
            piece = 1'($urandom);
            pos3  = 6'($urandom);
            pos4  = 8'($urandom);
         end
         tick(int'($urandom_range(99)) < rdy_pct, st);
         n++;
         any = m_run[0] || m_run[1] || m_run[2];
      end
      if (any) chk("enum_timeout_cycles", n, 0);
      if (tail) tick(1'b1, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e[$];
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_busy[%0d]", i), int'(busy_w[i]), 0);
         chk($sformatf("rst_valid[%0d]", i), int'(vld_w[i]), 0);
         chk($sformatf("rst_done[%0d]", i), int'(done_w[i]), 0);
         chk($sformatf("rst_number[%0d]", i), int'(num_w[i]), 0);
         chk($sformatf("rst_origin[%0d]", i), o_org[i], 0);
      end
      rst = 1'b0;
      @(negedge clk);

      // King at (0,4) on 8x8 and at (15,0) on 16x16, ready held high.
      run_enum(1'b0, 0, 4, 15, 0, 100, -1, 1'b1);
      e = '{12, 13, 5, 3, 11};  cmp_q("t1_pos", pres_pos[0], e);
      e = '{0, 1, 2, 6, 7};     cmp_q("t1_num", pres_num[0], e);
      chk("t1_flag_cnt", pres_pos[1].size(), 8);
      e = '{241, 225, 224};     cmp_q("t1_w4_pos", pres_pos[2], e);

      // Knight in the corner.
      run_enum(1'b1, 0, 0, 8, 8, 100, -1, 1'b1);
      e = '{17, 10};            cmp_q("t2_pos", pres_pos[0], e);
      e = '{0, 1};              cmp_q("t2_num", pres_num[0], e);

      // King at (7,7) with off-board candidates flagged, coordinates wrapped.
      run_enum(1'b0, 7, 7, 3, 3, 100, -1, 1'b1);
      e = '{7, 0, 56, 48, 55, 54, 62, 6};  cmp_q("t3_pos", pres_pos[1], e);
      e = '{0, 0, 0, 0, 1, 1, 1, 0};      cmp_q("t3_inb", pres_inb[1], e);

      // Knight at (3,3) under random backpressure.
      run_enum(1'b1, 3, 3, 5, 9, 50, -1, 1'b1);
      e = '{44, 37, 21, 12, 10, 17, 33, 42};
      cmp_q("t4_flag_pos", pres_pos[1], e);
      cmp_q("t4_skip_pos", pres_pos[0], e);

      // A start pulse mid-enumeration must not disturb it.
      run_enum(1'b0, 2, 2, 1, 14, 100, 3, 1'b1);
      e = '{26, 27, 19, 11, 10, 9, 17, 25};  cmp_q("t5_pos", pres_pos[0], e);

      // Reset while the flagging instance presents index 3.
      piece = 1'b0;
      pos3  = 6'd27;
      pos4  = 8'h55;
      tick(1'b1, 1'b1);
      repeat (3) tick(1'b1, 1'b0);
      chk("t6_pre_number", int'(num_w[1]), 3);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t6_busy[%0d]", i), int'(busy_w[i]), 0);
         chk($sformatf("t6_valid[%0d]", i), int'(vld_w[i]), 0);
         chk($sformatf("t6_done[%0d]", i), int'(done_w[i]), 0);
         m_run[i]  = 1'b0;
         m_done[i] = 1'b0;
         m_k[i]    = 0;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) tick(1'b1, 1'b0);

      // Random back-to-back enumerations, next start lands in the done cycle.
      for (int t = 0; t < 30; t++)
         run_enum(1'($urandom), int'($urandom_range(7)), int'($urandom_range(7)),
                  int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(100, 30)), int'($urandom_range(12)),
                  t == 29);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
